// File: rtl/ram_readback_checker.sv
// ram_readback_checker
// Watches the RAM write port to learn which addresses hold data, then on a
// start pulse walks the read port over every address and checks that each
// written word equals its own (zero-extended) address. Results hold in DONE.
//
// Handshake: start is a single-cycle request sampled on the rising clock edge
// and accepted only in IDLE or DONE; busy is high for exactly DEPTH cycles
// after acceptance, and done (with pass/err_count/first_err_*) rises on the
// following cycle and holds until reset or the next accepted start.
module ram_readback_checker #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4,
    parameter int WIDTH     = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic                 start,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_en,
    input  logic [WIDTH-1:0]     rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_BITS:0]   err_count,
    output logic [ADDR_BITS-1:0] first_err_addr,
    output logic [WIDTH-1:0]     first_err_data,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [DEPTH-1:0]   written;
    logic               mismatch;
    logic [ADDR_BITS:0] err_next;
    logic               last_addr;

    assign state_dbg = state;

    // Compare the current read word against its address, only for entries
    // that have been written; the bitmap value is the one before this edge.
    always_comb begin
        mismatch  = 1'b0;
        err_next  = err_count;
        last_addr = (rd_addr == ADDR_BITS'(DEPTH - 1));
        if (state == SCAN && written[rd_addr] && (rd_data != WIDTH'(rd_addr))) begin
            mismatch = 1'b1;
            err_next = err_count + (ADDR_BITS + 1)'(1);
        end
    end

    // Record every snooped write; only reset clears the bitmap.
    always_ff @(posedge clock) begin
        if (reset) begin
            written <= '0;
        end else if (wr_en) begin
            written[wr_addr] <= 1'b1;
        end
    end

    // Scan control and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            rd_addr        <= '0;
            rd_en          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= SCAN;
                        rd_addr        <= '0;
                        rd_en          <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                    end
                end
                SCAN: begin
                    err_count <= err_next;
                    // The first error of a scan is the one seen while the count is still zero.
                    if (mismatch && err_count == '0) begin
                        first_err_addr <= rd_addr;
                        first_err_data <= rd_data;
                    end
                    rd_addr <= rd_addr + ADDR_BITS'(1);
                    if (last_addr) begin
                        state <= DONE;
                        rd_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rd_addr <= '0;
                    rd_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Directed bench for ram_readback_checker with a small combinational-read RAM
// model. The model is written by snooped writes (wr_en) and by unsnooped
// pokes used to plant garbage or corrupt words behind the checker's back.
module tb_ram_readback_checker;

    localparam int DEPTH     = 16;
    localparam int ADDR_BITS = 4;
    localparam int WIDTH     = 32;

    logic                 clock;
    logic                 reset;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 start;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_en;
    logic [WIDTH-1:0]     rd_data;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ADDR_BITS:0]   err_count;
    logic [ADDR_BITS-1:0] first_err_addr;
    logic [WIDTH-1:0]     first_err_data;
    logic [1:0]           state_dbg;

    logic                 poke_en;
    logic [ADDR_BITS-1:0] poke_addr;
    logic [WIDTH-1:0]     poke_data;
    logic [WIDTH-1:0]     mem [DEPTH];

    int checks = 0;
    int errors = 0;

    ram_readback_checker #(
        .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .WIDTH(WIDTH)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .start(start), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM model: combinational read, write at the edge
    assign rd_data = mem[rd_addr];
    always @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic ram_write(input int a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = ADDR_BITS'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic ram_poke(input int a, input logic [WIDTH-1:0] d);
        poke_en = 1'b1; poke_addr = ADDR_BITS'(a); poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic fill_garbage();
        for (int i = 0; i < DEPTH; i++) ram_poke(i, 32'hA5A5_0100 + WIDTH'(i));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Pulse start, follow the scan cycle by cycle, then check the results on
    // cycle DEPTH+1 after the start edge. restart_at re-pulses start while
    // rd_addr equals it; same_wr_at writes that address with its own value
    // in the very cycle it is being read.
    task automatic run_scan(input string tag, input int exp_err, input int exp_fa,
                            input logic [WIDTH-1:0] exp_fd, input int restart_at,
                            input int same_wr_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == restart_at) start = 1'b1;
            if (i == same_wr_at) begin
                wr_en = 1'b1; wr_addr = ADDR_BITS'(i); wr_data = WIDTH'(i);
            end
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_rden"}, rd_en, 1'b1);
            chk({tag, "_done_low"}, done, 1'b0);
            chk({tag, "_rdaddr"}, rd_addr, WIDTH'(i));
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_rden_end"}, rd_en, 1'b0);
        chk({tag, "_rdaddr_end"}, rd_addr, 0);
        chk({tag, "_state"}, state_dbg, 2);
        chk({tag, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
        chk({tag, "_errcnt"}, err_count, WIDTH'(exp_err));
        chk({tag, "_first_addr"}, first_err_addr, WIDTH'(exp_fa));
        chk({tag, "_first_data"}, first_err_data, exp_fd);
        // Results must hold a few more cycles
        tick(); tick();
        chk({tag, "_hold_done"}, done, 1'b1);
        chk({tag, "_hold_errcnt"}, err_count, WIDTH'(exp_err));
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        do_reset();
        fill_garbage();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_rden", rd_en, 0);
        chk("rst_rdaddr", rd_addr, 0);
        chk("rst_first_addr", first_err_addr, 0);
        chk("rst_first_data", first_err_data, 0);
        chk("rst_state", state_dbg, 0);

        // No writes: nothing is compared even though the RAM holds garbage
        run_scan("empty", 0, 0, 0, -1, -1);

        // Every address written with its own value
        for (int k = 0; k < DEPTH; k++) ram_write(k, WIDTH'(k));
        run_scan("full", 0, 0, 0, -1, -1);

        // Corrupt address 5 behind the checker; start from DONE rescans
        ram_poke(5, 32'hDEAD_BEEF);
        run_scan("corrupt5", 1, 5, 32'hDEAD_BEEF, -1, -1);

        // Repaired: the count is recomputed from zero
        ram_poke(5, 32'h5);
        run_scan("repaired", 0, 0, 0, -1, -1);

        // Start during SCAN is ignored; done still on the 17th cycle
        run_scan("restart", 0, 0, 0, 3, -1);

        // Same-cycle write: the compare sees the old word at address 7
        ram_poke(7, 32'h0000_1234);
        run_scan("samecyc", 1, 7, 32'h0000_1234, -1, 7);
        run_scan("after_samecyc", 0, 0, 0, -1, -1);

        // Only addresses 2 and 9 written; 9 holds 7
        do_reset();
        fill_garbage();
        ram_write(2, 32'h2);
        ram_write(9, 32'h7);
        run_scan("sparse", 1, 9, 32'h7, -1, -1);

        // Reset at SCAN cycle 7 with an error already counted at address 2
        ram_poke(2, 32'hFFFF_0002);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        chk("mid_busy", busy, 1);
        chk("mid_errcnt", err_count, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_errcnt", err_count, 0);
        chk("abort_rden", rd_en, 0);
        chk("abort_rdaddr", rd_addr, 0);
        chk("abort_first_addr", first_err_addr, 0);
        chk("abort_state", state_dbg, 0);
        tick();

        // Bitmap cleared: garbage everywhere still passes
        run_scan("post_reset", 0, 0, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_readback_checker.md
Name: ram_readback_checker

Overview:
- Downstream consumer of the 16x32 RAM test harness, whose write side stores each write address as its own data word.
- Snoops the RAM write port to record which addresses have been written.
- On a start pulse, drives the RAM read port across every address and compares the combinational read data against the zero-extended address.
- Reports pass/fail, an error count, and the first failing address and data.

Parameters:
- DEPTH, 16, number of RAM words; must equal 2^ADDR_BITS.
- ADDR_BITS, 4, RAM address width.
- WIDTH, 32, RAM data width; must be >= ADDR_BITS.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  snooped RAM write enable (write mask is always 1).
- wr_addr  in  ADDR_BITS  snooped RAM write address.
- start  in  1  one-cycle request to begin a scan.
- rd_addr  out  ADDR_BITS  to RAM read_addr.
- rd_en  out  1  to RAM read_en.
- rd_data  in  WIDTH  from RAM read_data; combinational read (isSyncRead=0), valid in the same cycle as rd_addr.
- busy  out  1  scan in progress.
- done  out  1  scan complete; results valid.
- pass  out  1  valid while done; 1 = no mismatches.
- err_count  out  ADDR_BITS+1  number of mismatching written entries.
- first_err_addr  out  ADDR_BITS  address of the first mismatch.
- first_err_data  out  WIDTH  read data at the first mismatch.

Behaviour:
- Reset (sync, active-high; takes priority over everything):
  - State goes to IDLE; the written bitmap (DEPTH bits) is cleared.
  - rd_addr=0, rd_en=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, first_err_data=0.
  - Reset asserted mid-scan aborts the scan: IDLE and all-zero outputs on the next cycle.
- Bitmap:
  - Each cycle with wr_en=1 sets bit[wr_addr] at the clock edge.
  - This happens in every state; bits are never cleared except by reset.
- State IDLE:
  - rd_en=0, rd_addr=0.
  - start=1 moves the state to SCAN. Also clears err_count, first_err_*, done and pass, and loads rd_addr=0.
- State SCAN:
  - busy=1, rd_en=1.
  - Each cycle, when the bitmap bit for rd_addr is set (value at the start of the cycle), compare rd_data against the zero-extended rd_addr.
  - On mismatch: err_count increments. If this is the first error of the scan, capture rd_addr into first_err_addr and rd_data into first_err_data.
  - Entries whose bitmap bit is clear are skipped (no compare, no error).
  - rd_addr increments by 1 each cycle.
  - The cycle with rd_addr = DEPTH-1 is the last compare; the state then moves to DONE and rd_addr wraps to 0.
  - start is ignored while in SCAN.
- Same-cycle write to the address being read: the RAM updates at the edge, so rd_data carries the old word. The compare uses the old word and the pre-update bitmap bit; the new write affects only later scans.
- Latency:
  - start is sampled at edge E.
  - SCAN occupies the DEPTH cycles after E.
  - done=1 from the DEPTH+1th cycle after E.
  - The whole scan runs at one address per cycle with no stalls.
- State DONE:
  - busy=0, rd_en=0.
  - done=1; pass = (err_count==0).
  - Results hold until reset or the next start.
  - start=1 in DONE behaves exactly like start in IDLE: clears results and rescans.
- Arithmetic:
  - err_count is ADDR_BITS+1 bits, which covers a maximum of DEPTH errors; no saturation is needed.
  - The address increment is modulo DEPTH.

Test Plan:
- Reset, no writes, pulse start:
  - busy=1 for exactly 16 cycles, rd_addr walks 0..15.
  - Then done=1, pass=1, err_count=0.
- Write addr k with data k for k=0..15 via a RAM model, then start: pass=1, err_count=0, done 17 cycles after the start edge.
- Same as the previous case, but corrupt the model at addr 5 to 0xDEADBEEF: err_count=1, first_err_addr=5, first_err_data=0xDEADBEEF, pass=0.
- Write only addrs 2 and 9, with addr 9 holding 0x7 and all other entries garbage: only addr 9 flags. err_count=1, first_err_addr=9, first_err_data=0x7.
- Start restart cases:
  - Start pulsed again during SCAN at cycle 4: no effect; done still arrives at cycle 17.
  - Start in DONE: done drops, a new 16-cycle scan runs, and the error count is recomputed from zero.
- Reset mid-operation:
  - Assert reset at SCAN cycle 7: next cycle IDLE, busy=0, done=0, err_count=0.
  - A subsequent start with no writes yields pass=1, which confirms the bitmap was cleared.
